btn_debounce: RTL and testbench

- Input conditioning stage that sits directly upstream of the Prac_2 sequence detector.
- Takes a raw, bouncy push-button or switch level and synchronises it to clk with a 2-flop synchroniser.
- Debounces it with a stability counter and produces the clean level b that feeds the detector's b input.
- Also produces single-cycle rise and fall pulses for other lab logic.

---
 rtl/prac_pkg.sv | 13 +
 rtl/sync_2ff.sv | 29 ++
 rtl/btn_debounce.sv | 108 ++++++++++
 tb/tb_btn_debounce.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/prac_pkg.sv
// Shared constants and state encoding for the Prac_2 lab input-conditioning logic.
package prac_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } deb_state_e;

  // Short count for simulation; board builds pass the long one as STABLE_CYCLES.
  localparam int DEB_CYCLES_SIM   = 4;
  localparam int DEB_CYCLES_BOARD = 1_000_000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous lab inputs, one independent chain per bit.
module sync_2ff #(
  parameter int   W       = 1,
  parameter logic RST_VAL = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  for (genvar gi = 0; gi < W; gi++) begin : g_bit
    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        meta_reg <= RST_VAL;
        sync_reg <= RST_VAL;
      end else begin
        meta_reg <= d[gi];
        sync_reg <= meta_reg;
      end
    end

    assign q[gi] = sync_reg;
  end

endmodule

// File: rtl/btn_debounce.sv
// Debounces a raw button level into b, with registered one-cycle rise/fall pulses
// and a busy flag while a candidate transition is being timed.
module btn_debounce
  import prac_pkg::*;
#(
  parameter int   STABLE_CYCLES = DEB_CYCLES_SIM,
  parameter int   CNT_W         = 20,
  parameter logic INIT_LEVEL    = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic b,
  output logic b_rise,
  output logic b_fall,
  output logic busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam bit               SINGLE   = (STABLE_CYCLES == 1);

  logic             s2;
  logic             mismatch;
  deb_state_e       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             b_reg, b_next;
  logic             rise_reg, rise_next;
  logic             fall_reg, fall_next;

  sync_2ff #(
    .W       (1),
    .RST_VAL (INIT_LEVEL)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_raw),
    .q   (s2)
  );

  assign mismatch = (s2 != b_reg);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      b_reg     <= INIT_LEVEL;
      rise_reg  <= 1'b0;
      fall_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      b_reg     <= b_next;
      rise_reg  <= rise_next;
      fall_reg  <= fall_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    b_next     = b_reg;
    rise_next  = 1'b0;
    fall_next  = 1'b0;

    unique case (state_reg)
      ST_IDLE: begin
        if (mismatch && SINGLE) begin
          b_next    = s2;
          rise_next = s2;
          fall_next = !s2;
          cnt_next  = '0;
        end else if (mismatch) begin
          cnt_next   = CNT_W'(1);
          state_next = ST_COUNT;
        end else begin
          cnt_next = '0;
        end
      end

      ST_COUNT: begin
        // A return to b's level wins even on the edge the count would complete.
        if (!mismatch) begin
          cnt_next   = '0;
          state_next = ST_IDLE;
        end else if (cnt_reg == CNT_LAST) begin
          b_next     = s2;
          rise_next  = s2;
          fall_next  = !s2;
          cnt_next   = '0;
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      default: begin
        cnt_next   = '0;
        state_next = ST_IDLE;
      end
    endcase
  end

  assign b      = b_reg;
  assign b_rise = rise_reg;
  assign b_fall = fall_reg;
  assign busy   = (state_reg == ST_COUNT);

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: vector table, hand-written corner sequences and a
// randomized run against a run-length reference model, for 4-cycle and 1-cycle builds.
`timescale 1ns/1ps
module tb_btn_debounce;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn4 = 1'b0;
  logic btn1 = 1'b0;
  logic b4, rise4, fall4, busy4;
  logic b1, rise1, fall1, busy1;

  int n_cmp = 0;
  int n_err = 0;

  always #100 clk = ~clk;

  btn_debounce #(.STABLE_CYCLES(4), .CNT_W(20), .INIT_LEVEL(1'b0)) dut4 (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn4),
    .b       (b4),
    .b_rise  (rise4),
    .b_fall  (fall4),
    .busy    (busy4)
  );

  btn_debounce #(.STABLE_CYCLES(1), .CNT_W(20), .INIT_LEVEL(1'b0)) dut1 (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn1),
    .b       (b1),
    .b_rise  (rise1),
    .b_fall  (fall1),
    .busy    (busy1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic btn;
    logic b;
    logic rise;
    logic fall;
    logic busy;
  } vec_t;

  vec_t vecs[$];

  function automatic void addv(input logic btn, input logic eb, input logic er,
                               input logic ef, input logic ebz, input int reps);
    for (int i = 0; i < reps; i++) vecs.push_back('{btn, eb, er, ef, ebz});
  endfunction

  // Reference model: b flips once the synchronised level has disagreed with it
  // for n consecutive edges; any agreeing edge restarts the run.
  logic mb[2], mq1[2], mq2[2], mrise[2], mfall[2], mbusy[2];
  int   mrun[2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mb[k] = 1'b0; mq1[k] = 1'b0; mq2[k] = 1'b0;
      mrise[k] = 1'b0; mfall[k] = 1'b0; mbusy[k] = 1'b0; mrun[k] = 0;
    end
  endtask

  task automatic model_edge(input int k, input int n, input logic raw);
    mrise[k] = 1'b0;
    mfall[k] = 1'b0;
    if (mq2[k] != mb[k]) mrun[k] = mrun[k] + 1;
    else                 mrun[k] = 0;
    if (mrun[k] == n) begin
      mb[k]    = ~mb[k];
      mrise[k] = mb[k];
      mfall[k] = ~mb[k];
      mrun[k]  = 0;
    end
    mbusy[k] = (mrun[k] != 0);
    mq2[k] = mq1[k];
    mq1[k] = raw;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic rb;

    // Press, release, five short bursts, boundary glitch, then a clean 4-cycle press.
    addv(1, 0, 0, 0, 0, 2); addv(1, 0, 0, 0, 1, 3); addv(1, 1, 1, 0, 0, 1); addv(1, 1, 0, 0, 0, 2);
    addv(0, 1, 0, 0, 0, 2); addv(0, 1, 0, 0, 1, 3); addv(0, 0, 0, 1, 0, 1); addv(0, 0, 0, 0, 0, 2);
    for (int i = 0; i < 5; i++) begin
      addv(1, 0, 0, 0, 0, 2); addv(0, 0, 0, 0, 1, 2); addv(0, 0, 0, 0, 0, 2);
    end
    addv(1, 0, 0, 0, 0, 2); addv(1, 0, 0, 0, 1, 1); addv(0, 0, 0, 0, 1, 2); addv(0, 0, 0, 0, 0, 2);
    addv(1, 0, 0, 0, 0, 2); addv(1, 0, 0, 0, 1, 3); addv(1, 1, 1, 0, 0, 1); addv(1, 1, 0, 0, 0, 1);
    addv(0, 1, 0, 0, 0, 2); addv(0, 1, 0, 0, 1, 3); addv(0, 0, 0, 1, 0, 1); addv(0, 0, 0, 0, 0, 1);

    // Reset hold with the button pressed.
    rst = 1'b0; btn4 = 1'b1; btn1 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_b", b4, 0); chk("rst_rise", rise4, 0); chk("rst_fall", fall4, 0);
    chk("rst_busy", busy4, 0); chk("rst_b1", b1, 0);
    $display("reset hold: b=%0b rise=%0b fall=%0b busy=%0b", b4, rise4, fall4, busy4);
    btn4 = 1'b0; btn1 = 1'b0; rst = 1'b1;
    repeat (3) @(negedge clk);

    foreach (vecs[i]) begin
      btn4 = vecs[i].btn;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d_b", i), b4, vecs[i].b);
      chk($sformatf("vec%0d_rise", i), rise4, vecs[i].rise);
      chk($sformatf("vec%0d_fall", i), fall4, vecs[i].fall);
      chk($sformatf("vec%0d_busy", i), busy4, vecs[i].busy);
      if (!vecs[i].busy) chk($sformatf("vec%0d_cnt", i), dut4.cnt_reg, 0);
      $display("vec %0d: btn=%0b b=%0b rise=%0b fall=%0b busy=%0b", i, btn4, b4, rise4, fall4, busy4);
    end

    // Asynchronous reset in the middle of a count.
    btn4 = 1'b1;
    repeat (7) @(negedge clk);
    chk("midrst_pre_b", b4, 1);
    btn4 = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrst_pre_cnt", dut4.cnt_reg, 2);
    chk("midrst_pre_busy", busy4, 1);
    #30 rst = 1'b0;
    #1;
    chk("midrst_b", b4, 0); chk("midrst_busy", busy4, 0); chk("midrst_cnt", dut4.cnt_reg, 0);
    $display("mid-count reset: b=%0b busy=%0b cnt=%0d", b4, busy4, dut4.cnt_reg);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single-cycle build: a one-cycle pulse toggles b at E0+2 and back at E0+3.
    btn1 = 1'b1;
    @(negedge clk);
    btn1 = 1'b0;
    @(negedge clk);
    chk("s1_e1_b", b1, 0);
    @(negedge clk);
    chk("s1_e2_b", b1, 1); chk("s1_e2_rise", rise1, 1); chk("s1_e2_busy", busy1, 0);
    @(negedge clk);
    chk("s1_e3_b", b1, 0); chk("s1_e3_fall", fall1, 1); chk("s1_e3_rise", rise1, 0);
    $display("single-cycle build: b=%0b fall=%0b", b1, fall1);

    // Randomized run against the model, with occasional asynchronous resets.
    #30 rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    btn4 = 1'b0; btn1 = 1'b0; rb = 1'b0;
    model_reset();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 4) == 0) rb = ~rb;
      btn4 = rb; btn1 = rb;
      if ($urandom_range(0, 299) == 0) begin
        #30 rst = 1'b0;
        #1;
        chk("rnd_rst_b4", b4, 0); chk("rnd_rst_busy4", busy4, 0); chk("rnd_rst_b1", b1, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        $display("rnd %0d: async reset", c);
      end else begin
        @(posedge clk);
        model_edge(0, 4, rb);
        model_edge(1, 1, rb);
        @(negedge clk);
        chk($sformatf("rnd%0d_b4", c), b4, mb[0]);
        chk($sformatf("rnd%0d_rise4", c), rise4, mrise[0]);
        chk($sformatf("rnd%0d_fall4", c), fall4, mfall[0]);
        chk($sformatf("rnd%0d_busy4", c), busy4, mbusy[0]);
        chk($sformatf("rnd%0d_b1", c), b1, mb[1]);
        chk($sformatf("rnd%0d_rise1", c), rise1, mrise[1]);
        chk($sformatf("rnd%0d_fall1", c), fall1, mfall[1]);
        chk($sformatf("rnd%0d_busy1", c), busy1, mbusy[1]);
        $display("rnd %0d: btn=%0b b4=%0b busy4=%0b b1=%0b", c, rb, b4, busy4, b1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
